// File: rtl/sap_pkg.sv
// Shared constants for the SAP-1 style control sequencer: opcodes, one-hot
// T-states and the packed control word driven onto the datapath.
package sap_pkg;

  localparam int NUM_T = 6;

  typedef enum logic [3:0] {
    OP_LDA = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  // T_NONE is the parked ring value once HLT has executed.
  typedef enum logic [NUM_T-1:0] {
    T_NONE = 6'b000000,
    T1     = 6'b000001,
    T2     = 6'b000010,
    T3     = 6'b000100,
    T4     = 6'b001000,
    T5     = 6'b010000,
    T6     = 6'b100000
  } tstate_e;

  typedef struct packed {
    logic pc_inc;
    logic pc_out;
    logic mar_in;
    logic ram_out;
    logic ir_in;
    logic ir_out;
    logic acc_in;
    logic acc_out;
    logic b_in;
    logic alu_sub;
    logic alu_out;
    logic out_in;
  } ctrl_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle of the sequencer's instruction input, control word and status, as
// seen from the sequencer (master) and from the datapath (slave).
interface control_sequencer_if;
  import sap_pkg::*;

  logic [3:0]       opcode;
  logic             pc_inc, pc_out, mar_in, ram_out, ir_in, ir_out;
  logic             acc_in, acc_out, b_in, alu_sub, alu_out, out_in;
  logic [NUM_T-1:0] t_state;
  logic             halted;

  modport master (
    input  opcode,
    output pc_inc, pc_out, mar_in, ram_out, ir_in, ir_out,
    output acc_in, acc_out, b_in, alu_sub, alu_out, out_in,
    output t_state, halted
  );

  modport slave (
    output opcode,
    input  pc_inc, pc_out, mar_in, ram_out, ir_in, ir_out,
    input  acc_in, acc_out, b_in, alu_sub, alu_out, out_in,
    input  t_state, halted
  );

endinterface

// File: rtl/ring_counter.sv
// One-hot T-state ring T1..T6. Dropping enable parks the ring at all-zero,
// which is how the sequencer freezes after HLT until the next reset.
module ring_counter
  import sap_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic [NUM_T-1:0] t_state
);

  tstate_e state_q, state_d;

  always_comb begin
    // NOTE: default assigned first so every path writes state_d; no latch.
    state_d = T_NONE;
    if (enable) begin
      unique case (state_q)
        T1:      state_d = T2;
        T2:      state_d = T3;
        T3:      state_d = T4;
        T4:      state_d = T5;
        T5:      state_d = T6;
        T6:      state_d = T1;
        default: state_d = T_NONE;
      endcase
    end
  end

  // NOTE: non-blocking for state; reset is synchronous and wins over enable.
  always_ff @(posedge clock) begin
    if (reset) state_q <= T1;
    else       state_q <= state_d;
  end

  assign t_state = state_q;

endmodule

// File: rtl/control_sequencer.sv
// Moore control unit: decodes the current T-state and opcode into datapath
// control strobes, and latches halted when HLT reaches T4.
module control_sequencer
  import sap_pkg::*;
#(
  parameter int NUM_T = sap_pkg::NUM_T
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       opcode,
  output logic             pc_inc,
  output logic             pc_out,
  output logic             mar_in,
  output logic             ram_out,
  output logic             ir_in,
  output logic             ir_out,
  output logic             acc_in,
  output logic             acc_out,
  output logic             b_in,
  output logic             alu_sub,
  output logic             alu_out,
  output logic             out_in,
  output logic [NUM_T-1:0] t_state,
  output logic             halted
);

  ctrl_t ctrl;
  logic  hlt_now;

  assign hlt_now = (t_state == T4) && (opcode == OP_HLT);

  always_ff @(posedge clock) begin
    if (reset)        halted <= 1'b0;
    else if (hlt_now) halted <= 1'b1;
  end

  // The ring parks on the same edge that sets halted, so t_state is zero
  // from the first halted cycle onward.
  ring_counter u_ring (
    .clock   (clock),
    .reset   (reset),
    .enable  (!halted && !hlt_now),
    .t_state (t_state)
  );

  // OUT holds acc_out across T4 and T5: the accumulator's bus driver is
  // registered, so out_in must capture one cycle after acc_out is first seen.
  always_comb begin
    ctrl = '0;
    if (!reset) begin
      case (t_state)
        T1: begin ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; end
        T2: ctrl.pc_inc = 1'b1;
        T3: begin ctrl.ram_out = 1'b1; ctrl.ir_in = 1'b1; end
        T4: case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin ctrl.ir_out = 1'b1; ctrl.mar_in = 1'b1; end
          OP_OUT:                 ctrl.acc_out = 1'b1;
          default:                ;
        endcase
        T5: case (opcode)
          OP_LDA: begin ctrl.ram_out = 1'b1; ctrl.acc_in = 1'b1; end
          OP_ADD: begin ctrl.ram_out = 1'b1; ctrl.b_in = 1'b1; end
          OP_SUB: begin ctrl.ram_out = 1'b1; ctrl.b_in = 1'b1; ctrl.alu_sub = 1'b1; end
          OP_OUT: begin ctrl.acc_out = 1'b1; ctrl.out_in = 1'b1; end
          default: ;
        endcase
        T6: case (opcode)
          OP_ADD: begin ctrl.alu_out = 1'b1; ctrl.acc_in = 1'b1; end
          OP_SUB: begin ctrl.alu_out = 1'b1; ctrl.acc_in = 1'b1; ctrl.alu_sub = 1'b1; end
          default: ;
        endcase
        default: ;
      endcase
    end
  end

  assign pc_inc  = ctrl.pc_inc;
  assign pc_out  = ctrl.pc_out;
  assign mar_in  = ctrl.mar_in;
  assign ram_out = ctrl.ram_out;
  assign ir_in   = ctrl.ir_in;
  assign ir_out  = ctrl.ir_out;
  assign acc_in  = ctrl.acc_in;
  assign acc_out = ctrl.acc_out;
  assign b_in    = ctrl.b_in;
  assign alu_sub = ctrl.alu_sub;
  assign alu_out = ctrl.alu_out;
  assign out_in  = ctrl.out_in;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: a micro-program table plus step counter predicts the
// control word every cycle; directed instructions pin the table to literals.
module tb_control_sequencer;
  import sap_pkg::*;

  localparam logic [11:0] C_PC_INC  = 12'h800;
  localparam logic [11:0] C_PC_OUT  = 12'h400;
  localparam logic [11:0] C_MAR_IN  = 12'h200;
  localparam logic [11:0] C_RAM_OUT = 12'h100;
  localparam logic [11:0] C_IR_IN   = 12'h080;
  localparam logic [11:0] C_IR_OUT  = 12'h040;
  localparam logic [11:0] C_ACC_IN  = 12'h020;
  localparam logic [11:0] C_ACC_OUT = 12'h010;
  localparam logic [11:0] C_B_IN    = 12'h008;
  localparam logic [11:0] C_ALU_SUB = 12'h004;
  localparam logic [11:0] C_ALU_OUT = 12'h002;
  localparam logic [11:0] C_OUT_IN  = 12'h001;

  typedef logic [11:0] prog_t [6];

  logic clock = 1'b0;
  logic reset = 1'b1;
  control_sequencer_if bus();

  control_sequencer #(.NUM_T(6)) dut (
    .clock   (clock),
    .reset   (reset),
    .opcode  (bus.opcode),
    .pc_inc  (bus.pc_inc),
    .pc_out  (bus.pc_out),
    .mar_in  (bus.mar_in),
    .ram_out (bus.ram_out),
    .ir_in   (bus.ir_in),
    .ir_out  (bus.ir_out),
    .acc_in  (bus.acc_in),
    .acc_out (bus.acc_out),
    .b_in    (bus.b_in),
    .alu_sub (bus.alu_sub),
    .alu_out (bus.alu_out),
    .out_in  (bus.out_in),
    .t_state (bus.t_state),
    .halted  (bus.halted)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  logic [11:0] ctrl;
  assign ctrl = {bus.pc_inc, bus.pc_out, bus.mar_in, bus.ram_out, bus.ir_in, bus.ir_out,
                 bus.acc_in, bus.acc_out, bus.b_in, bus.alu_sub, bus.alu_out, bus.out_in};

  // Model: step number 1..6 plus halted flag; control word from a table.
  logic [11:0] ucode [16][7];
  int m_t      = 1;
  bit m_halted = 1'b0;

  initial begin
    for (int op = 0; op < 16; op++) begin
      for (int t = 0; t < 7; t++) ucode[op][t] = '0;
      ucode[op][1] = C_PC_OUT | C_MAR_IN;
      ucode[op][2] = C_PC_INC;
      ucode[op][3] = C_RAM_OUT | C_IR_IN;
    end
    ucode[0][4]  = C_IR_OUT | C_MAR_IN;
    ucode[0][5]  = C_RAM_OUT | C_ACC_IN;
    ucode[1][4]  = C_IR_OUT | C_MAR_IN;
    ucode[1][5]  = C_RAM_OUT | C_B_IN;
    ucode[1][6]  = C_ALU_OUT | C_ACC_IN;
    ucode[2][4]  = C_IR_OUT | C_MAR_IN;
    ucode[2][5]  = C_RAM_OUT | C_B_IN | C_ALU_SUB;
    ucode[2][6]  = C_ALU_OUT | C_ACC_IN | C_ALU_SUB;
    ucode[14][4] = C_ACC_OUT;
    ucode[14][5] = C_ACC_OUT | C_OUT_IN;
  end

  always @(posedge clock) begin
    if (reset) begin
      m_t      <= 1;
      m_halted <= 1'b0;
    end else if (!m_halted) begin
      if (m_t == 4 && bus.opcode == 4'hF) m_halted <= 1'b1;
      else                                m_t      <= (m_t == 6) ? 1 : m_t + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (cmp_en) begin
      check("cyc_t_state", 32'(bus.t_state),
            m_halted ? 32'd0 : (32'd1 << (m_t - 1)));
      check("cyc_halted", 32'(bus.halted), 32'(m_halted));
      check("cyc_ctrl", 32'(ctrl),
            (reset || m_halted) ? 32'd0 : 32'(ucode[bus.opcode][m_t]));
      checks++;
      assert ($countones({bus.pc_out, bus.ram_out, bus.ir_out, bus.acc_out, bus.alu_out}) <= 1
              && $onehot0(bus.t_state))
      else begin
        errors++;
        $display("FAIL bus_exclusive: drivers %b t_state %b at %0t",
                 {bus.pc_out, bus.ram_out, bus.ir_out, bus.acc_out, bus.alu_out},
                 bus.t_state, $time);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Entered just after the edge into T1; leaves just after the edge into the next T1.
  task automatic run_instr(input string name, input logic [3:0] op, input prog_t exp);
    bus.opcode = op;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check($sformatf("%s_t%0d_state", name, i + 1), 32'(bus.t_state), 32'd1 << i);
      check($sformatf("%s_t%0d_ctrl", name, i + 1), 32'(ctrl), 32'(exp[i]));
      if (i < 5) tick();
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.opcode = 4'h0;
    reset      = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    cmp_en = 1'b1;
    check("rst_t_state", 32'(bus.t_state), 32'h01);
    check("rst_halted", 32'(bus.halted), 32'h0);
    check("rst_ctrl", 32'(ctrl), 32'h0);
    reset = 1'b0;

    run_instr("lda", 4'h0, '{C_PC_OUT | C_MAR_IN, C_PC_INC, C_RAM_OUT | C_IR_IN,
                             C_IR_OUT | C_MAR_IN, C_RAM_OUT | C_ACC_IN, 12'h000});
    check("lda_wrap", 32'(bus.t_state), 32'h01);
    run_instr("sub", 4'h2, '{C_PC_OUT | C_MAR_IN, C_PC_INC, C_RAM_OUT | C_IR_IN,
                             C_IR_OUT | C_MAR_IN, C_RAM_OUT | C_B_IN | C_ALU_SUB,
                             C_ALU_OUT | C_ACC_IN | C_ALU_SUB});
    run_instr("out", 4'hE, '{C_PC_OUT | C_MAR_IN, C_PC_INC, C_RAM_OUT | C_IR_IN,
                             C_ACC_OUT, C_ACC_OUT | C_OUT_IN, 12'h000});
    run_instr("nop", 4'h7, '{C_PC_OUT | C_MAR_IN, C_PC_INC, C_RAM_OUT | C_IR_IN,
                             12'h000, 12'h000, 12'h000});

    // Reset in T5 of ADD abandons it and restarts the fetch.
    bus.opcode = 4'h1;
    repeat (4) tick();
    check("addrst_t5_ctrl", 32'(ctrl), 32'(C_RAM_OUT | C_B_IN));
    reset = 1'b1;
    #1;
    check("addrst_ctrl_in_reset", 32'(ctrl), 32'h0);
    tick();
    check("addrst_t_state", 32'(bus.t_state), 32'h01);
    check("addrst_ctrl_held", 32'(ctrl), 32'h0);
    reset = 1'b0;
    #1;
    check("addrst_restart_ctrl", 32'(ctrl), 32'(C_PC_OUT | C_MAR_IN));

    // HLT: halted rises on the T4 edge, then everything stays frozen.
    bus.opcode = 4'hF;
    repeat (3) tick();
    check("hlt_t4_halted", 32'(bus.halted), 32'h0);
    check("hlt_t4_ctrl", 32'(ctrl), 32'h0);
    tick();
    check("hlt_halted", 32'(bus.halted), 32'h1);
    for (int i = 0; i < 20; i++) begin
      bus.opcode = (i % 2 == 0) ? 4'h0 : 4'hE;
      tick();
      check("hlt_frozen_t_state", 32'(bus.t_state), 32'h0);
      check("hlt_frozen_ctrl", 32'(ctrl), 32'h0);
      check("hlt_frozen_halted", 32'(bus.halted), 32'h1);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("hlt_rst_t_state", 32'(bus.t_state), 32'h01);
    check("hlt_rst_halted", 32'(bus.halted), 32'h0);

    // Random instruction stream; opcodes change only at the start of fetch.
    for (int i = 0; i < 1000; i++) begin
      if (reset)                                         reset = 1'b0;
      else if (m_halted || $urandom_range(0, 99) == 0)   reset = 1'b1;
      if (m_t == 1) begin
        if ($urandom_range(0, 19) == 0) bus.opcode = 4'hF;
        else                            bus.opcode = 4'($urandom_range(0, 14));
      end
      tick();
    end

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
